// File: rtl/pc_seq_if.sv
// pc_seq control/status bundle: decoder side drives the
// enables and targets, the counter drives PC and status.
interface pc_seq_if #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8,
  parameter int SP_W  = 3
);
  logic             stall;
  logic             branch_en;
  logic             jump_en;
  logic             call_en;
  logic             ret_en;
  logic [PC_W-1:0]  Target;
  logic [OFF_W-1:0] Offset;
  logic [PC_W-1:0]  PC;
  logic             halt;
  logic [1:0]       fault;
  logic [SP_W-1:0]  sp;

  modport master (
    output stall, branch_en, jump_en,
    output call_en, ret_en, Target, Offset,
    input  PC, halt, fault, sp
  );

  modport slave (
    input  stall, branch_en, jump_en,
    input  call_en, ret_en, Target, Offset,
    output PC, halt, fault, sp
  );
endinterface

// File: rtl/pc_seq.sv
// Program counter with branch/jump/call/return and sticky halt.
// Return-address stack built only when PC_RAS_EN is defined.
module pc_seq #(
  parameter int PC_W      = 10,
  parameter int OFF_W     = 8,
  parameter int HALT_ADDR = 63,
  parameter int RAS_DEPTH = 4
) (
  input logic     CLK,
  input logic     init_n,
  pc_seq_if.slave bus
);
  localparam int SP_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_halt;
  logic [1:0]      r_fault;

  logic            w_over;
  logic [PC_W-1:0] w_inc;
  logic [PC_W:0]   w_jsum;

  assign w_over = r_pc > PC_W'(HALT_ADDR);
  assign w_inc  = r_pc + PC_W'(1);
  // bit PC_W set means the jump left 0..2^PC_W-1
  assign w_jsum = {1'b0, r_pc}
                + {{(PC_W+1-OFF_W){bus.Offset[OFF_W-1]}},
                   bus.Offset};

`ifdef PC_RAS_EN
  localparam int IDX_W =
    (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [SP_W-1:0] r_sp;
  logic [PC_W-1:0] r_ras [RAS_DEPTH];
  logic [SP_W-1:0] w_spm1;
  logic            w_full;
  logic            w_empty;
  logic            w_push;

  assign w_spm1  = r_sp - SP_W'(1);
  assign w_full  = r_sp == SP_W'(RAS_DEPTH);
  assign w_empty = r_sp == '0;
  assign w_push  = (r_state == RUN) && !w_over
                && !bus.stall && !bus.ret_en
                && bus.call_en && !w_full;

  always_ff @(posedge CLK) begin
    if (w_push)
      r_ras[r_sp[IDX_W-1:0]] <= w_inc;
  end

  assign bus.sp = r_sp;
`else
  logic w_unused;
  assign w_unused = bus.ret_en;
  assign bus.sp   = '0;
`endif

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      r_state <= RUN;
      r_pc    <= '0;
      r_halt  <= 1'b0;
      r_fault <= 2'd0;
`ifdef PC_RAS_EN
      r_sp    <= '0;
`endif
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_over) begin
            r_state <= HALTED;
            r_halt  <= 1'b1;
            r_fault <= 2'd0;
          end else if (bus.stall) begin
            r_pc <= r_pc;
`ifdef PC_RAS_EN
          end else if (bus.ret_en) begin
            if (w_empty) begin
              r_state <= HALTED;
              r_halt  <= 1'b1;
              r_fault <= 2'd3;
            end else begin
              r_pc <= r_ras[w_spm1[IDX_W-1:0]];
              r_sp <= w_spm1;
            end
          end else if (bus.call_en) begin
            if (w_full) begin
              r_state <= HALTED;
              r_halt  <= 1'b1;
              r_fault <= 2'd2;
            end else begin
              r_pc <= bus.Target;
              r_sp <= r_sp + SP_W'(1);
            end
`else
          end else if (bus.call_en) begin
            r_pc <= bus.Target;
`endif
          end else if (bus.branch_en) begin
            r_pc <= bus.Target;
          end else if (bus.jump_en) begin
            if (w_jsum[PC_W]) begin
              r_state <= HALTED;
              r_halt  <= 1'b1;
              r_fault <= 2'd1;
            end else begin
              r_pc <= w_jsum[PC_W-1:0];
            end
          end else begin
            r_pc <= w_inc;
          end
        end
        HALTED: begin
          r_state <= HALTED;
        end
      endcase
    end
  end

  assign bus.PC    = r_pc;
  assign bus.halt  = r_halt;
  assign bus.fault = r_fault;
endmodule
